// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_pkg
// Purpose  : Shared constants, state type and helpers for nibble_serial_adder.
// Revision : 1.0  initial release
// ============================================================================
package nibble_serial_adder_pkg;

    // Width of the reused arithmetic slice.
    localparam int NIBBLE_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble counter width. One bit minimum so the counter stays a real
    // vector when only one nibble step is needed.
    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_full_adder4.sv
`default_nettype none
// ============================================================================
// Module   : full_adder4
// Purpose  : 4-bit ripple-carry adder slice, the arithmetic core that
//            nibble_serial_adder reuses once per cycle.
// Revision : 1.0  initial release
// ============================================================================
module full_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] carry;

    assign carry[0] = ci;

    // One full-adder cell per bit, carry rippling upward.
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign co = carry[4];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : WIDTH-bit adder built from one 4-bit slice stepped least
//            significant nibble first, with valid/ready on both sides.
//            Optional macro SERIAL_ADD_OVF_EN adds a signed overflow output.
// Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = cnt_width(NIB);

    // Reject widths the nibble sequencer cannot cover exactly.
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;

    logic [3:0]         slice_sum;
    logic               slice_co;
    logic [WIDTH-1:0]   sum_next;

    full_adder4 u_slice (
        .a  (a_q[3:0]),
        .b  (b_q[3:0]),
        .ci (carry_q),
        .s  (slice_sum),
        .co (slice_co)
    );

    // New nibble enters at the top; after NIB steps the first one sits at bit 0.
    if (WIDTH == NIBBLE_W) begin : g_single
        assign sum_next = slice_sum;
    end else begin : g_multi
        assign sum_next = {slice_sum, sum_q[WIDTH-1:NIBBLE_W]};
    end

`ifdef SERIAL_ADD_OVF_EN
    // Carry into the slice's top bit, recovered from its sum bit.
    logic bit3_carry;
    assign bit3_carry = a_q[3] ^ b_q[3] ^ slice_sum[3];
`endif

    // Sequencer: accept operands, step the slice NIB times, present result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= c_in;
                        sum_q    <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> NIBBLE_W;
                    b_q     <= b_q >> NIBBLE_W;
                    sum_q   <= sum_next;
                    carry_q <= slice_co;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_W'(NIB - 1)) begin
                        sum       <= sum_next;
                        c_out     <= slice_co;
                        out_valid <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        ovf       <= bit3_carry ^ slice_co;
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Self-checking bench for nibble_serial_adder (WIDTH=16 and
//            WIDTH=4 instances). SERIAL_ADD_OVF_EN also checks ovf.
// Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out;
    logic [15:0] a, b, sum;
`ifdef SERIAL_ADD_OVF_EN
    logic        ovf;
`endif

    logic        in_valid4, in_ready4, c_in4, out_valid4, out_ready4, c_out4;
    logic [3:0]  a4, b4, sum4;
`ifdef SERIAL_ADD_OVF_EN
    logic        ovf4;
`endif

    int vectors;
    int miscompares;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .c_in      (c_in4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .c_out     (c_out4)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=16 operation; expected result from plain integer addition.
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input int stall);
        logic [16:0] exp;
        int          cyc;
        bit          busy_ready;
        exp = {1'b0, ta} + {1'b0, tb} + 17'(tc);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta; b = tb; c_in = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        // operands must only matter at the acceptance edge
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
        cyc = 1;
        busy_ready = 1'b0;
        while (!out_valid && cyc < 20) begin
            if (in_ready) busy_ready = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("latency16", 32'(cyc), 32'd5);
        chk("in_ready_busy", 32'(busy_ready | in_ready), 32'd0);
        chk("sum16", 32'(sum), 32'(exp[15:0]));
        chk("c_out16", 32'(c_out), 32'(exp[16]));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf16", 32'(ovf), 32'((ta[15] == tb[15]) && (exp[15] != ta[15])));
`endif
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'(exp[15:0]));
            chk("hold_c_out", 32'(c_out), 32'(exp[16]));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff_valid", 32'(out_valid), 32'd0);
        chk("handoff_in_ready", 32'(in_ready), 32'd1);
        chk("retain_sum", 32'(sum), 32'(exp[15:0]));
    endtask

    // One WIDTH=4 operation.
    task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        logic [4:0] exp;
        int         cyc;
        exp = {1'b0, ta} + {1'b0, tb} + 5'(tc);
        cyc = 0;
        while (!in_ready4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        a4 = ta; b4 = tb; c_in4 = tc; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); c_in4 = 1'($urandom);
        cyc = 1;
        while (!out_valid4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency4", 32'(cyc), 32'd2);
        chk("sum4", 32'(sum4), 32'(exp[3:0]));
        chk("c_out4", 32'(c_out4), 32'(exp[4]));
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        chk("handoff4", 32'(out_valid4), 32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; c_in4 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_out_valid4", 32'(out_valid4), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run16(16'h1234, 16'h4321, 1'b0, 0);
        run16(16'hFFFF, 16'h0001, 1'b0, 0);
        run16(16'hFFFF, 16'h0000, 1'b1, 0);
        run16(16'h00F0, 16'h0F10, 1'b0, 3);
        run16(16'h7FFF, 16'h0001, 1'b0, 0);
        run16(16'h8000, 16'h8000, 1'b0, 1);
        run16(16'h1234, 16'h4321, 1'b1, 0);

        // Reset during RUN aborts the operation
        while (!in_ready) @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_no_output", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        run16(16'h0003, 16'h0004, 1'b0, 0);

        // Randomized operations with random backpressure
        for (int i = 0; i < 20; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        // WIDTH=4 instance
        run4(4'h9, 4'h8, 1'b1);
        run4(4'hF, 4'h0, 1'b1);
        for (int i = 0; i < 12; i++)
            run4(4'($urandom), 4'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
